// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the IF/ID skid register: state encodings (which double as
// occupancy counts), the NOP instruction encoding and the reset/zero constant.
package if_id_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [63:0] ZERO     = 64'd0;

endpackage

// File: rtl/if_id_entry.sv
// One PC+instruction holding register with asynchronous reset and load enable.
// Contents change only on load, so idle entries never toggle.
module if_id_entry
  import if_id_skid_reg_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst
);

  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc   <= PC_W'(ZERO);
      r_inst <= INST_W'(ZERO);
    end else if (i_load) begin
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end
  end

  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/if_id_skid_reg.sv
// Two-entry IF/ID skid buffer (main + skid register) with registered in_ready.
// Optional macro IF_ID_NOP_INJECT_EN forces out_inst to a NOP while out_valid is low.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds its payload while valid is high and ready is low.

  state_e              r_state;
  state_e              w_next;
  logic                r_in_ready;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_load_main;
  logic                w_load_skid;
  logic [PC_W-1:0]     w_main_d_pc;
  logic [INST_W-1:0]   w_main_d_inst;
  logic [PC_W-1:0]     w_main_pc;
  logic [INST_W-1:0]   w_main_inst;
  logic [PC_W-1:0]     w_skid_pc;
  logic [INST_W-1:0]   w_skid_inst;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_next      = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_next      = ST_BUSY;
            w_load_main = 1'b1;
          end
        end
        ST_BUSY: begin
          case ({w_in_xfer, w_out_xfer})
            2'b11: w_load_main = 1'b1;
            2'b10: begin
              w_next      = ST_FULL;
              w_load_skid = 1'b1;
            end
            2'b01: w_next = ST_EMPTY;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_next      = ST_BUSY;
            w_load_main = 1'b1;
          end
        end
        default: w_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      // Derived from next state so in_ready has no combinational input path.
      r_in_ready <= (w_next != ST_FULL);
    end
  end

  // Main reloads from skid when draining FULL, otherwise straight from fetch.
  assign w_main_d_pc   = (r_state == ST_FULL) ? w_skid_pc   : in_pc;
  assign w_main_d_inst = (r_state == ST_FULL) ? w_skid_inst : in_inst;

  if_id_entry #(.PC_W(PC_W), .INST_W(INST_W)) u_main (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load_main),
    .i_pc   (w_main_d_pc),
    .i_inst (w_main_d_inst),
    .o_pc   (w_main_pc),
    .o_inst (w_main_inst)
  );

  if_id_entry #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load_skid),
    .i_pc   (in_pc),
    .i_inst (in_inst),
    .o_pc   (w_skid_pc),
    .o_inst (w_skid_inst)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = r_state;
  assign out_pc    = w_main_pc;

`ifdef IF_ID_NOP_INJECT_EN
  assign out_inst = out_valid ? w_main_inst : INST_W'(NOP_INST);
`else
  assign out_inst = w_main_inst;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: directed streaming/backpressure/flush/reset
// vectors followed by a long randomized in_valid/out_ready/flush run.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  occupancy;

  int          total = 0;
  int          bad   = 0;
  int          occ_m = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_idle_inst;

  always #5 clk = ~clk;

  if_id_skid_reg #(.PC_W(32), .INST_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return 32'hA000_0000 ^ pc;
  endfunction

  // Drive one cycle of stimulus; at the edge update the occupancy model and
  // push any accepted entry as the expected response.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    logic acc;
    logic outx;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = mk_inst(pc);
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    acc  = v && (occ_m != 2) && !fl;
    outx = (occ_m != 0) && rdy;
    if (fl) begin
      occ_m = 0;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back({pc, mk_inst(pc)});
      occ_m = occ_m + int'(acc) - int'(outx);
    end
    #1;
  endtask

  // Monitor: flag checks against the model, head-of-queue check while valid,
  // pop on every output transfer.
  always @(negedge clk) begin
    logic [63:0] head;
    chk("in_ready", 32'(in_ready), 32'(occ_m != 2));
    chk("out_valid", 32'(out_valid), 32'(occ_m != 0));
    chk("occupancy", 32'(occupancy), 32'(occ_m));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got pc %h with empty expected queue at %0t", out_pc, $time);
      end else begin
        head = exp_q[0];
        chk("out_pc", out_pc, head[63:32]);
        chk("out_inst", out_inst, head[31:0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] pc;
`ifdef IF_ID_NOP_INJECT_EN
    exp_idle_inst = NOP;
`else
    exp_idle_inst = 32'h0;
`endif
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, exp_idle_inst);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // streaming at one per cycle
    cycle(1'b1, 32'h0, 1'b1, 1'b0);
    chk("stream_occ", 32'(occupancy), 32'd1);
    cycle(1'b1, 32'h4, 1'b1, 1'b0);
    chk("stream_occ", 32'(occupancy), 32'd1);
    cycle(1'b1, 32'h8, 1'b1, 1'b0);
    chk("stream_pc8", out_pc, 32'h8);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // backpressure: fill, hold, drain in order
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 1'b0, 1'b0);
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_pc", out_pc, 32'h10);
    cycle(1'b1, 32'h30, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_hold_pc", out_pc, 32'h10);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_drain_pc", out_pc, 32'h14);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // flush while FULL with a concurrent input that must be dropped
    cycle(1'b1, 32'h1C, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 32'h18, 1'b0, 1'b1);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef IF_ID_NOP_INJECT_EN
    chk("flush_out_inst", out_inst, 32'h0000_0013);
`else
    chk("flush_out_inst", out_inst, 32'hA000_001C);
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // flush in BUSY with an output transfer in the same cycle
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush_busy_occ", 32'(occupancy), 32'd0);

    // asynchronous reset mid-cycle while FULL
    cycle(1'b1, 32'h50, 1'b0, 1'b0);
    cycle(1'b1, 32'h54, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    occ_m = 0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_inst", out_inst, exp_idle_inst);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 32'h60, 1'b1, 1'b0);
    chk("post_rst_pc", out_pc, 32'h60);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // randomized traffic with occasional flushes
    pc = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      logic v;
      logic r;
      logic f;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 63) == 0);
      cycle(v, pc, r, f);
      pc = pc + 32'd4;
    end
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width in bits.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with clk and rst being the only clock and reset ports.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  fetch presents an entry.
REQ-008 SHALL have port in_ready  output  1  block can accept; registered (no combinational path from any input).
REQ-009 SHALL have port in_pc  input  PC_W  fetch PC.
REQ-010 SHALL have port in_inst  input  INST_W  fetched instruction.
REQ-011 SHALL have port out_valid  output  1  decode-side entry valid.
REQ-012 SHALL have port out_ready  input  1  decode accepts.
REQ-013 SHALL have port out_pc  output  PC_W  PC of head entry.
REQ-014 SHALL have port out_inst  output  INST_W  instruction of head entry.
REQ-015 SHALL have port occupancy  output  2  held entries, 0..2.

Function
REQ-016 SHALL implement a two-entry skid buffer (main register plus skid register) with states EMPTY (0 entries), BUSY (1), FULL (2).
REQ-017 SHALL define input transfer as in_valid&in_ready and output transfer as out_valid&out_ready, both on the rising clk edge.
REQ-018 SHALL drive in_ready = 1 in EMPTY/BUSY and 0 in FULL.
REQ-019 SHALL drive out_valid = 1 in BUSY/FULL, with out_pc/out_inst always from the main register.
REQ-020 SHALL make an accepted entry visible at the output one cycle after acceptance (latency 1) when the block was EMPTY.
REQ-021 SHALL sustain one transfer per cycle in BUSY when in and out transfers coincide (state stays BUSY, main reloads).
REQ-022 SHALL apply these transitions: EMPTY+in -> BUSY; BUSY+in, no out -> FULL (entry into skid); BUSY+out, no in -> EMPTY; FULL+out -> BUSY (skid moves to main); FULL, no out -> FULL.
REQ-023 SHALL preserve strict FIFO order; no entry is dropped or duplicated absent flush.
REQ-024 SHALL hold out_pc/out_inst stable while out_valid=1 and out_ready=0.
REQ-025 SHALL give flush priority over all events: next state EMPTY; an input transfer in the flush cycle is discarded; an output transfer in the flush cycle still counts as consumed.
REQ-026 SHALL make occupancy equal the state encoding (EMPTY=0, BUSY=1, FULL=2); value 3 is never driven.
REQ-027 SHALL leave data registers unchanged when not loaded (no gratuitous toggling).

Reset
REQ-028 SHALL on rst assertion immediately enter EMPTY: out_valid=0, occupancy=0, in_ready=1, out_pc=0, out_inst=0, skid data=0.
REQ-029 SHALL abandon any mid-operation contents on reset; the first in_valid after deassertion is accepted on the first rising edge.

Configuration
REQ-030 SHALL, with macro IF_ID_NOP_INJECT_EN defined, drive out_inst = 32'h00000013 (ADDI x0,x0,0) whenever out_valid=0, including after flush and reset.
REQ-031 SHALL, without IF_ID_NOP_INJECT_EN, drive out_inst as the main register contents regardless of out_valid.

Structure
REQ-032 SHALL take the NOP encoding, the state encodings and the zero constant from the shared defines file.
REQ-033 SHALL be built around one sub-module, if_id_entry, a PC+instruction register with async reset and load enable, instantiated twice (main, skid).

Verification
REQ-034 SHALL verify streaming: in_valid=1 with pc 0x0,0x4,0x8, out_ready=1 -> outputs 0x0,0x4,0x8 on consecutive cycles, occupancy=1 steady.
REQ-035 SHALL verify backpressure: out_ready=0 with two pushes (0x10,0x14) -> occupancy=2, in_ready=0, out_pc=0x10 held; out_ready=1 -> 0x10 then 0x14 drain.
REQ-036 SHALL verify flush in FULL with in_valid=1 (pc 0x18) -> next cycle occupancy=0, out_valid=0, 0x18 never appears.
REQ-037 SHALL verify async reset asserted mid-cycle while FULL -> outputs zero/EMPTY before the next clk edge; in_ready=1.
REQ-038 SHALL verify IF_ID_NOP_INJECT_EN: after flush, out_inst=0x00000013; without the macro, out_inst retains the last main-register value.
REQ-039 SHALL verify random in_valid/out_ready over 10,000 cycles -> scoreboard shows in-order, lossless delivery and occupancy never 3.
